// File: rtl/ntsc_write_pack.sv
// ntsc_write_pack: pairs even/odd pixels into 36-bit words; flag rises the cycle after the completing pixel; show-ahead FIFO drained by done_ntsc.
// A full FIFO drops the completed word and sets sticky overflow; define NTSC_WRITE_STATS_EN to build the drop_count counter.
`ifndef LOG_HCOUNT
`define LOG_HCOUNT 10
`endif
`ifndef LOG_VCOUNT
`define LOG_VCOUNT 10
`endif
`ifndef LOG_MEM
`define LOG_MEM 36
`endif

module ntsc_write_pack #(
  parameter int FIFO_DEPTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [17:0]            pixel,
  input  logic [`LOG_HCOUNT-1:0] pixel_hcount,
  input  logic [`LOG_VCOUNT-1:0] pixel_vcount,
  output logic                   ntsc_flag,
  output logic [`LOG_MEM-1:0]    ntsc_pixel,
  output logic [`LOG_HCOUNT-1:0] ntsc_hcount,
  output logic [`LOG_VCOUNT-1:0] ntsc_vcount,
  input  logic                   done_ntsc,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int HW = `LOG_HCOUNT;
  localparam int VW = `LOG_VCOUNT;
  localparam int MW = `LOG_MEM;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic          last;
    logic [VW-1:0] v;
    logic [HW-1:0] h;
    logic [MW-1:0] word;
  } entry_t;

  logic          r_half;
  logic [17:0]   r_held_pix;
  logic [HW-1:0] r_held_h;
  logic [VW-1:0] r_held_v;
  entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_in_bounds;
  logic          w_odd;
  logic          w_half;
  logic [HW-1:0] w_held_h_next;
  logic          w_match;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  entry_t        w_entry;
  entry_t        w_head;

  assign w_in_bounds   = pixel_valid && (32'(pixel_hcount) < H_ACTIVE) && (32'(pixel_vcount) < V_ACTIVE);
  assign w_odd         = pixel_hcount[0];
  // frame_start makes this cycle's pixel see an EMPTY packer
  assign w_half        = r_half && !frame_start;
  assign w_held_h_next = r_held_h + HW'(1);
  assign w_match       = (pixel_hcount == w_held_h_next) && (pixel_vcount == r_held_v);
  assign w_push_req    = w_in_bounds && w_half && w_odd && w_match;
  assign w_pop         = done_ntsc && (r_count != '0);
  assign w_push        = w_push_req && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_last        = (32'(r_held_h) == H_ACTIVE - 2) && (32'(r_held_v) == V_ACTIVE - 1);
  assign w_entry       = '{last: w_last, v: r_held_v, h: r_held_h, word: MW'({pixel, r_held_pix})};
  assign w_head        = r_mem[r_rd_ptr];

  // Every in-bounds even pixel (re)latches; every in-bounds odd pixel leaves HALF.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_half     <= 1'b0;
      r_held_pix <= '0;
      r_held_h   <= '0;
      r_held_v   <= '0;
    end else if (w_in_bounds) begin
      if (!w_odd) begin
        r_half     <= 1'b1;
        r_held_pix <= pixel;
        r_held_h   <= pixel_hcount;
        r_held_v   <= pixel_vcount;
      end else begin
        r_half <= 1'b0;
      end
    end else if (frame_start) begin
      r_half <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  assign ntsc_flag   = (r_count != '0);
  assign ntsc_pixel  = w_head.word;
  assign ntsc_hcount = w_head.h;
  assign ntsc_vcount = w_head.v;
  assign frame_done  = w_pop && w_head.last;
  assign overflow    = r_overflow;

`ifdef NTSC_WRITE_STATS_EN
  logic [1:0]  w_pix_drop;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_count;

  always_comb begin
    w_pix_drop = 2'd0;
    if (w_in_bounds) begin
      if (!w_half && w_odd)              w_pix_drop = 2'd1;
      else if (w_half && !w_odd)         w_pix_drop = 2'd1;
      else if (w_half && w_odd && !w_match) w_pix_drop = 2'd2;
    end
  end

  assign w_drop_inc = w_pix_drop + {1'b0, frame_start && r_half};
  assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_inc);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) r_drop_count <= '0;
    else          r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ntsc_write_pack.sv
// Bench for ntsc_write_pack: scoreboard of expected words plus a stimulus table for packer corner cases.
`ifndef LOG_HCOUNT
`define LOG_HCOUNT 10
`endif
`ifndef LOG_VCOUNT
`define LOG_VCOUNT 10
`endif
`ifndef LOG_MEM
`define LOG_MEM 36
`endif

module tb_ntsc_write_pack;
`ifdef NTSC_WRITE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clock;
  logic                   reset_b;
  logic                   frame_start;
  logic                   pixel_valid;
  logic [17:0]            pixel;
  logic [`LOG_HCOUNT-1:0] pixel_hcount;
  logic [`LOG_VCOUNT-1:0] pixel_vcount;
  logic                   ntsc_flag;
  logic [`LOG_MEM-1:0]    ntsc_pixel;
  logic [`LOG_HCOUNT-1:0] ntsc_hcount;
  logic [`LOG_VCOUNT-1:0] ntsc_vcount;
  logic                   done_ntsc;
  logic                   frame_done;
  logic                   overflow;
  logic [15:0]            drop_count;

  ntsc_write_pack #(.FIFO_DEPTH(8), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clock(clock), .reset_b(reset_b), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel(pixel), .pixel_hcount(pixel_hcount), .pixel_vcount(pixel_vcount),
    .ntsc_flag(ntsc_flag), .ntsc_pixel(ntsc_pixel), .ntsc_hcount(ntsc_hcount),
    .ntsc_vcount(ntsc_vcount), .done_ntsc(done_ntsc), .frame_done(frame_done),
    .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic [35:0] word;
    int          h;
    int          v;
    bit          last;
  } exp_t;

  typedef struct {
    bit fs;
    bit vld;
    int h;
    int v;
    int dd;
    bit psh;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   fd_seen = 0;
  int   drop_tot = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [17:0] pf(input int h, input int v);
    logic [9:0] hh;
    logic [9:0] vv;
    hh = 10'(h);
    vv = 10'(v);
    return {vv[7:0], hh};
  endfunction

  function automatic vec_t mk(input bit fs, input bit vld, input int h, input int v, input int dd, input bit psh);
    vec_t r;
    r.fs = fs; r.vld = vld; r.h = h; r.v = v; r.dd = dd; r.psh = psh;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_word(input int h_odd, input int v);
    exp_t e;
    e.word = {pf(h_odd, v), pf(h_odd - 1, v)};
    e.h    = h_odd - 1;
    e.v    = v;
    e.last = (h_odd - 1 == 638) && (v == 479);
    q.push_back(e);
  endtask

  task automatic drive(input bit fs, input bit vld, input int h, input int v);
    frame_start  = fs;
    pixel_valid  = vld;
    pixel_hcount = 10'(h);
    pixel_vcount = 10'(v);
    pixel        = pf(h, v);
    @(posedge clock); #1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    done_ntsc = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
    @(posedge clock); #1;
    chk({nm, "_queue_left"}, 64'(q.size()), 64'd0);
    chk({nm, "_flag_after"}, 64'(ntsc_flag), 64'd0);
  endtask

  // Pops the scoreboard on every accepted done_ntsc and checks frame_done each cycle.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_fd;
    if (reset_b) begin
      exp_fd = 1'b0;
      if (ntsc_flag && done_ntsc) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got h=%0d v=%0d word=%0h, expected none", ntsc_hcount, ntsc_vcount, ntsc_pixel);
        end else begin
          e = q.pop_front();
          chk("head_word", 64'(ntsc_pixel), 64'(e.word));
          chk("head_hcount", 64'(ntsc_hcount), 64'(e.h));
          chk("head_vcount", 64'(ntsc_vcount), 64'(e.v));
          exp_fd = e.last;
          n_pop++;
        end
      end
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (frame_done) fd_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; pixel = '0;
    pixel_hcount = '0; pixel_vcount = '0; done_ntsc = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_flag", 64'(ntsc_flag), 64'd0);
    chk("rst_pixel", 64'(ntsc_pixel), 64'd0);
    chk("rst_hcount", 64'(ntsc_hcount), 64'd0);
    chk("rst_vcount", 64'(ntsc_vcount), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset_b = 1'b1;

    // Continuous line with done held high
    done_ntsc = 1'b1;
    drive(0, 1, 0, 0);
    chk("lat_flag_after_p0", 64'(ntsc_flag), 64'd0);
    expect_word(1, 0);
    drive(0, 1, 1, 0);
    chk("lat_flag_after_p1", 64'(ntsc_flag), 64'd1);
    for (int h = 2; h < 640; h++) begin
      if (h[0]) expect_word(h, 0);
      drive(0, 1, h, 0);
    end
    drain("line");
    chk("line_words", 64'(n_pop), 64'd320);
    chk("line_overflow", 64'(overflow), 64'd0);

    // Back-pressure: ten pairs into an 8-deep FIFO
    done_ntsc = 1'b0;
    drive(1, 0, 0, 0);
    for (int h = 0; h < 20; h++) begin
      if (h[0] && (h / 2) < 8) expect_word(h, 0);
      drive(0, 1, h, 0);
    end
    chk("bp_flag", 64'(ntsc_flag), 64'd1);
    chk("bp_head_h", 64'(ntsc_hcount), 64'd0);
    chk("bp_head_v", 64'(ntsc_vcount), 64'd0);
    chk("bp_head_word", 64'(ntsc_pixel), 64'({pf(1, 0), pf(0, 0)}));
    chk("bp_overflow", 64'(overflow), 64'd1);
    drain("bp");
    chk("bp_words", 64'(n_pop), 64'd328);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);
    chk("pre_table_drop", 64'(drop_count), 64'd0);

    // Packer corner cases: {fs, valid, h, v, drop delta, push}
    tbl.push_back(mk(0, 1,   4,   2, 0, 0));
    tbl.push_back(mk(0, 1,   6,   2, 1, 0));
    tbl.push_back(mk(0, 1,   7,   2, 0, 1));
    tbl.push_back(mk(0, 1,   9,   2, 1, 0));
    tbl.push_back(mk(0, 1, 640,   2, 0, 0));
    tbl.push_back(mk(0, 1, 799,   2, 0, 0));
    tbl.push_back(mk(0, 1,  10, 480, 0, 0));
    tbl.push_back(mk(0, 1,  11, 480, 0, 0));
    tbl.push_back(mk(0, 1, 638, 479, 0, 0));
    tbl.push_back(mk(0, 1, 639, 479, 0, 1));
    tbl.push_back(mk(0, 1, 100,   5, 0, 0));
    tbl.push_back(mk(0, 1, 700,   5, 0, 0));
    tbl.push_back(mk(0, 0, 101,   5, 0, 0));
    tbl.push_back(mk(1, 0,   0,   0, 1, 0));
    tbl.push_back(mk(0, 1,  20,   5, 0, 0));
    tbl.push_back(mk(1, 1,  21,   5, 2, 0));
    tbl.push_back(mk(1, 1,  22,   5, 0, 0));
    tbl.push_back(mk(0, 1,  23,   5, 0, 1));
    tbl.push_back(mk(0, 1,   8,   6, 0, 0));
    tbl.push_back(mk(0, 1,  11,   6, 2, 0));
    tbl.push_back(mk(0, 1,  12,   6, 0, 0));
    tbl.push_back(mk(0, 1,  13,   7, 2, 0));
    tbl.push_back(mk(0, 1,  13,   6, 1, 0));
    done_ntsc = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].psh) expect_word(tbl[i].h, tbl[i].v);
      drive(tbl[i].fs, tbl[i].vld, tbl[i].h, tbl[i].v);
      drop_tot += tbl[i].dd;
      chk($sformatf("tbl%0d_drop", i), 64'(drop_count), STATS ? 64'(drop_tot) : 64'd0);
    end
    drain("tbl");
    chk("tbl_words", 64'(n_pop), 64'd331);
    chk("frame_done_pulses", 64'(fd_seen), 64'd1);

    // Asynchronous reset with three words held
    done_ntsc = 1'b0;
    for (int h = 0; h < 6; h++) begin
      if (h[0]) expect_word(h, 10);
      drive(0, 1, h, 10);
    end
    @(posedge clock); #3;
    chk("pre_rst_flag", 64'(ntsc_flag), 64'd1);
    reset_b = 1'b0;
    #1;
    chk("arst_flag", 64'(ntsc_flag), 64'd0);
    chk("arst_pixel", 64'(ntsc_pixel), 64'd0);
    chk("arst_hcount", 64'(ntsc_hcount), 64'd0);
    chk("arst_vcount", 64'(ntsc_vcount), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_drop", 64'(drop_count), 64'd0);
    chk("arst_frame_done", 64'(frame_done), 64'd0);
    q.delete();
    @(posedge clock); #1;
    reset_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("post_rst_flag", 64'(ntsc_flag), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ntsc_write_pack.md
# ntsc_write_pack

Capture-side write packer between the camera/NTSC pixel stream and the memory interface. It accepts one 18-bit YCrCb pixel per valid cycle and pairs even and odd pixels into 36-bit memory words: the even pixel goes in [17:0] and the odd pixel in [35:18], which is the layout the VGA read path unpacks. Completed words are buffered in a small show-ahead FIFO and presented to the memory interface with a flag/done handshake, together with the word's frame address.

## Interface
- FIFO_DEPTH, 8, word buffer depth; power of two, minimum 2
- H_ACTIVE, 640, pixels at or above this hcount are dropped
- V_ACTIVE, 480, lines at or above this vcount are dropped

Ports:
- clock  in  1  system clock; all logic is single-clock
- reset_b  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of a camera frame
- pixel_valid  in  1  qualifies pixel, pixel_hcount, pixel_vcount
- pixel  in  18  YCrCb pixel
- pixel_hcount  in  `LOG_HCOUNT  pixel column
- pixel_vcount  in  `LOG_VCOUNT  pixel line
- ntsc_flag  out  1  write request; high while the FIFO is non-empty
- ntsc_pixel  out  `LOG_MEM  packed word at the FIFO head
- ntsc_hcount  out  `LOG_HCOUNT  hcount of the word's even pixel
- ntsc_vcount  out  `LOG_VCOUNT  vcount of the word
- done_ntsc  in  1  one-cycle pulse from the memory interface: head word written
- frame_done  out  1  one-cycle pulse when the last word of the frame (638,479) is written
- overflow  out  1  sticky; set when a completed word is dropped because the FIFO is full
- drop_count  out  16  pixels discarded by the packer (see Configuration)

## Operation
- Out-of-bounds filter: a valid pixel with hcount >= H_ACTIVE or vcount >= V_ACTIVE is ignored silently. It is not counted and does not change packer state.
- The packer has two states.
- State EMPTY:
  - Even-hcount pixel: latch pixel, hcount and vcount, then go to HALF.
  - Odd-hcount pixel: drop it, increment drop_count, stay in EMPTY.
- State HALF:
  - Odd pixel with hcount == held_hcount+1 and vcount == held_vcount: form word {pixel, held_pixel}, push it with address (held_hcount, held_vcount), go to EMPTY.
  - Even pixel: discard the held half and add 1 to drop_count. Latch the new pixel and stay in HALF.
  - Any other odd pixel: discard both the held half and the new pixel, add 2 to drop_count, go to EMPTY.
- frame_start forces EMPTY. A held half is discarded and counted as 1. frame_start has priority over a pixel_valid in the same cycle, and that pixel is also processed as if in EMPTY.
- FIFO entry contents: 36-bit word, hcount, vcount, and a last tag. The tag is set when the address is (H_ACTIVE-2, V_ACTIVE-1).
- Push rule: a push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the word is dropped and overflow is set. The packer still returns to EMPTY.
- Memory handshake:
  - ntsc_flag = FIFO non-empty.
  - ntsc_pixel, ntsc_hcount and ntsc_vcount always show the head entry and are stable while ntsc_flag is high and no done_ntsc has arrived.
  - done_ntsc with ntsc_flag high pops the head. done_ntsc with ntsc_flag low is ignored.
  - frame_done is high in the cycle done_ntsc pops an entry whose last tag is set.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: ntsc_flag=0, ntsc_pixel=0, ntsc_hcount=0, ntsc_vcount=0, frame_done=0, overflow=0, drop_count=0. FIFO empty, packer in EMPTY.
- Reset is asynchronous: assertion mid-transfer clears everything immediately, including any word being presented.
- Latency: the completing odd pixel is sampled at edge N and ntsc_flag rises after edge N (visible in cycle N+1) when the FIFO was empty.
- After a pop at edge M, the next head word is valid in cycle M+1. Sustained throughput is 1 word/cycle.
- frame_done is combinational from done_ntsc and the head tag, so it lands in the same cycle as the pop.
- overflow clears only on reset.

## Configuration
- NTSC_WRITE_STATS_EN:
  - Defined: drop_count increments per the Operation rules and saturates at 16'hFFFF.
  - Undefined: drop_count is tied to 0 and no counter logic is built.
- overflow, packing and the handshake are identical either way.

## Test plan
- Continuous line: after reset, 640 valid pixels on line 0 -> 320 words. Word k has ntsc_hcount=2k, ntsc_vcount=0 and ntsc_pixel={p[2k+1],p[2k]}. With done_ntsc held high, ntsc_flag first rises one cycle after pixel 1.
- Back-pressure: done_ntsc tied low for 10 pixel pairs with FIFO_DEPTH=8 -> ntsc_flag=1, the head stays the (0,0) word, the first 8 words are retained, the 9th and 10th are dropped, and overflow=1.
- Broken pairs: pixel sequence hcount 4, 6, 7, then 9 -> one word at hcount 6 is emitted; drop_count=2 with the macro defined and 0 without it.
- Bounds: pixels at hcount 640..799 and at vcount 480 -> no pushes and drop_count unchanged.
- Frame end: pair (638,479),(639,479), then a done_ntsc pop -> frame_done=1 for exactly that cycle. Then frame_start while in HALF -> the held half is discarded and drop_count increases by 1.
- Async reset: assert reset_b low while the FIFO holds 3 words -> ntsc_flag drops to 0 before the next clock edge, and all outputs show reset values.
